// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the byte-wide RAM port between the instruction fetcher
// (32-bit reads) and the load/store buffer (1/2/4-byte loads and stores).
// Requests are split into byte beats, assembled little-endian, and each
// finished request returns a one-cycle done pulse.
// Optional: MEM_ARBITER_IO_STALL_EN holds back I/O-mapped stores while the
// UART buffer reports full.
module mem_arbiter #(
  parameter int         ADDR_W     = 32,
  parameter logic [1:0] IO_BASE_HI = 2'b11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clr,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full,
  input  logic              IF_req,
  input  logic [ADDR_W-1:0] IF_addr,
  output logic              IF_done,
  output logic [31:0]       IF_data,
  input  logic              LSB_req,
  input  logic              LSB_wr,
  input  logic [ADDR_W-1:0] LSB_addr,
  input  logic [1:0]        LSB_size,
  input  logic [31:0]       LSB_wdata,
  output logic              LSB_done,
  output logic [31:0]       LSB_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE
  } state_t;

  state_t            state_q, state_d;
  logic              owner_lsb_q, owner_lsb_d;   // requester being served
  logic              last_lsb_q, last_lsb_d;     // most recent grant went to LSB
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        size_q, size_d;             // beats in transaction: 1, 2 or 4
  logic [1:0]        cnt_q, cnt_d;               // index of current beat
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rbuf_q, rbuf_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              mem_wr_q, mem_wr_d;
  logic              if_done_q, if_done_d;
  logic              lsb_done_q, lsb_done_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       lsb_rdata_q, lsb_rdata_d;

  logic              io_block;
  logic              lsb_ok;
  logic              pick_lsb;
  logic [2:0]        lsb_beats;
  logic [1:0]        cnt_inc;
  logic              last_beat;

`ifdef MEM_ARBITER_IO_STALL_EN
  assign io_block = LSB_wr && (LSB_addr[17:16] == IO_BASE_HI) && io_buffer_full;
`else
  logic [2:0] unused_io;
  assign unused_io = {io_buffer_full, IO_BASE_HI};
  assign io_block  = 1'b0;
`endif

  // Arbitration helpers: eligible LSB request, round-robin pick, beat count.
  always_comb begin
    lsb_ok    = LSB_req && !io_block;
    pick_lsb  = lsb_ok && (!IF_req || !last_lsb_q);
    case (LSB_size)
      2'd0:    lsb_beats = 3'd1;
      2'd1:    lsb_beats = 3'd2;
      default: lsb_beats = 3'd4;
    endcase
    cnt_inc   = cnt_q + 2'd1;
    last_beat = ({1'b0, cnt_q} + 3'd1) >= size_q;
  end

  // State register; everything freezes while rdy is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_lsb_q <= 1'b0;
      last_lsb_q  <= 1'b0;
      addr_q      <= '0;
      size_q      <= '0;
      cnt_q       <= '0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      mem_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      lsb_done_q  <= 1'b0;
      if_data_q   <= '0;
      lsb_rdata_q <= '0;
    end else if (rdy) begin
      state_q     <= state_d;
      owner_lsb_q <= owner_lsb_d;
      last_lsb_q  <= last_lsb_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      cnt_q       <= cnt_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
      if_done_q   <= if_done_d;
      lsb_done_q  <= lsb_done_d;
      if_data_q   <= if_data_d;
      lsb_rdata_q <= lsb_rdata_d;
    end
  end

  // Next-state: grant in IDLE, then sequence read or write beats.
  always_comb begin
    state_d     = state_q;
    owner_lsb_d = owner_lsb_q;
    last_lsb_d  = last_lsb_q;
    addr_d      = addr_q;
    size_d      = size_q;
    cnt_d       = cnt_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    mem_wr_d    = mem_wr_q;
    if_done_d   = 1'b0;
    lsb_done_d  = 1'b0;
    if_data_d   = if_data_q;
    lsb_rdata_d = lsb_rdata_q;

    case (state_q)
      IDLE: begin
        mem_wr_d = 1'b0;
        // The done pulse of the previous transaction blocks a grant,
        // which guarantees the idle cycle between transactions.
        if (!clr && !if_done_q && !lsb_done_q && (IF_req || lsb_ok)) begin
          owner_lsb_d = pick_lsb;
          last_lsb_d  = pick_lsb;
          cnt_d       = '0;
          rbuf_d      = '0;
          if (pick_lsb) begin
            addr_d  = LSB_addr;
            size_d  = lsb_beats;
            wdata_d = LSB_wdata;
            mem_a_d = LSB_addr;
            if (LSB_wr) begin
              state_d    = WRITE;
              mem_wr_d   = 1'b1;
              mem_dout_d = LSB_wdata[7:0];
            end else begin
              state_d = READ;
            end
          end else begin
            addr_d  = IF_addr;
            size_d  = 3'd4;
            mem_a_d = IF_addr;
            state_d = READ;
          end
        end
      end

      READ: begin
        if (clr) begin
          state_d  = IDLE;
          mem_wr_d = 1'b0;
        end else begin
          // Buffer is cleared at grant, so unread high bytes stay zero.
          rbuf_d[{cnt_q, 3'b000} +: 8] = mem_din;
          if (last_beat) begin
            state_d = IDLE;
            if (owner_lsb_q) begin
              lsb_done_d  = 1'b1;
              lsb_rdata_d = rbuf_d;
            end else begin
              if_done_d = 1'b1;
              if_data_d = rbuf_d;
            end
          end else begin
            cnt_d   = cnt_inc;
            mem_a_d = addr_q + ADDR_W'(cnt_inc);
          end
        end
      end

      WRITE: begin
        // Stores always run to completion, even across a flush.
        if (last_beat) begin
          state_d    = IDLE;
          mem_wr_d   = 1'b0;
          lsb_done_d = 1'b1;
        end else begin
          cnt_d      = cnt_inc;
          mem_a_d    = addr_q + ADDR_W'(cnt_inc);
          mem_dout_d = wdata_q[{cnt_inc, 3'b000} +: 8];
        end
      end

      default: begin
        state_d  = IDLE;
        mem_wr_d = 1'b0;
      end
    endcase
  end

  assign mem_a     = mem_a_q;
  assign mem_dout  = mem_dout_q;
  assign mem_wr    = mem_wr_q & rdy;
  assign IF_done   = if_done_q;
  assign IF_data   = if_data_q;
  assign LSB_done  = lsb_done_q;
  assign LSB_rdata = lsb_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a byte-wide RAM model whose read
// data follows mem_a combinationally.
module tb_mem_arbiter;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst, rdy, clr;
  logic [7:0]        mem_din, mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;
  logic              io_buffer_full;
  logic              IF_req;
  logic [ADDR_W-1:0] IF_addr;
  logic              IF_done;
  logic [31:0]       IF_data;
  logic              LSB_req, LSB_wr;
  logic [ADDR_W-1:0] LSB_addr;
  logic [1:0]        LSB_size;
  logic [31:0]       LSB_wdata;
  logic              LSB_done;
  logic [31:0]       LSB_rdata;

  mem_arbiter #(.ADDR_W(ADDR_W), .IO_BASE_HI(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .IF_req(IF_req), .IF_addr(IF_addr), .IF_done(IF_done), .IF_data(IF_data),
    .LSB_req(LSB_req), .LSB_wr(LSB_wr), .LSB_addr(LSB_addr), .LSB_size(LSB_size),
    .LSB_wdata(LSB_wdata), .LSB_done(LSB_done), .LSB_rdata(LSB_rdata)
  );

  always #5 clk = ~clk;

  logic [7:0]  ram [0:4095];
  logic        pl_we;
  logic [11:0] pl_a;
  logic [7:0]  pl_d;

  assign mem_din = ram[mem_a[11:0]];

  always @(posedge clk) begin
    if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
    else if (pl_we) ram[pl_a] <= pl_d;
  end

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [7:0] d);
    pl_a  = a;
    pl_d  = d;
    pl_we = 1'b1;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic wait_done(input bit lsb, input int max, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(lsb ? LSB_done : IF_done) && cyc < max);
  endtask

  task automatic lsb_txn(input string tag, input bit wr, input logic [31:0] a,
                         input logic [1:0] sz, input logic [31:0] wd,
                         input int exp_lat, input logic [31:0] exp_rd);
    int cyc;
    LSB_req   = 1'b1;
    LSB_wr    = wr;
    LSB_addr  = a;
    LSB_size  = sz;
    LSB_wdata = wd;
    wait_done(1'b1, 20, cyc);
    check({tag, " latency"}, cyc, exp_lat);
    check({tag, " done"}, LSB_done, 1);
    if (!wr) check({tag, " rdata"}, LSB_rdata, exp_rd);
    LSB_req = 1'b0;
    @(negedge clk);
    check({tag, " pulse width"}, LSB_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int ev [8];
    int n_ev;
    int exp_ev [4];
    logic [31:0] wd;
    bit seen;

    rst = 1'b1; rdy = 1'b1; clr = 1'b0; io_buffer_full = 1'b0;
    IF_req = 1'b0; IF_addr = '0;
    LSB_req = 1'b0; LSB_wr = 1'b0; LSB_addr = '0; LSB_size = '0; LSB_wdata = '0;
    pl_we = 1'b0; pl_a = '0; pl_d = '0;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    check("rst mem_a", mem_a, 0);
    check("rst mem_wr", mem_wr, 0);
    check("rst mem_dout", mem_dout, 0);
    check("rst IF_done", IF_done, 0);
    check("rst IF_data", IF_data, 0);
    check("rst LSB_done", LSB_done, 0);
    check("rst LSB_rdata", LSB_rdata, 0);

    preload(12'h100, 8'h13);
    preload(12'h101, 8'h00);
    preload(12'h102, 8'h00);
    preload(12'h103, 8'h93);
    preload(12'h021, 8'hCD);
    preload(12'hFFE, 8'h01);
    preload(12'hFFF, 8'h02);
    preload(12'h000, 8'h03);
    preload(12'h001, 8'h04);
    rst = 1'b0;

    // IF 32-bit fetch from 0x100
    IF_req  = 1'b1;
    IF_addr = 32'h100;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("if mem_a beat", mem_a, 32'h100 + j);
      check("if early done", IF_done, 0);
    end
    @(negedge clk);
    check("if done", IF_done, 1);
    check("if data", IF_data, 32'h93000013);
    IF_req = 1'b0;
    @(negedge clk);
    check("if done width", IF_done, 0);
    check("if data hold", IF_data, 32'h93000013);

    // Single-byte store, only the low byte of wdata is written
    LSB_req = 1'b1; LSB_wr = 1'b1; LSB_addr = 32'h20; LSB_size = 2'd0;
    LSB_wdata = 32'h123456AB;
    @(negedge clk);
    check("st1 mem_wr", mem_wr, 1);
    check("st1 mem_a", mem_a, 32'h20);
    check("st1 mem_dout", mem_dout, 8'hAB);
    check("st1 early done", LSB_done, 0);
    @(negedge clk);
    check("st1 mem_wr end", mem_wr, 0);
    check("st1 done", LSB_done, 1);
    LSB_req = 1'b0;
    check("st1 ram20", ram[12'h020], 8'hAB);
    check("st1 ram21", ram[12'h021], 8'hCD);
    @(negedge clk);

    lsb_txn("ld2", 1'b0, 32'h20, 2'd1, 32'h0, 3, 32'h0000CDAB);
    // size 3 behaves as 4 bytes; address wraps past the top
    lsb_txn("ldwrap", 1'b0, 32'hFFFFFFFE, 2'd3, 32'h0, 5, 32'h04030201);

    // Round-robin with both requesters held; LSB wins the first tie
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    IF_req = 1'b1; IF_addr = 32'h100;
    LSB_req = 1'b1; LSB_wr = 1'b0; LSB_addr = 32'h20; LSB_size = 2'd0;
    n_ev = 0;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (LSB_done && n_ev < 8) begin
        ev[n_ev] = 100 + c; n_ev++;
        check("rr lsb data", LSB_rdata, 32'h000000AB);
      end
      if (IF_done && n_ev < 8) begin
        ev[n_ev] = c; n_ev++;
        check("rr if data", IF_data, 32'h93000013);
      end
    end
    IF_req = 1'b0; LSB_req = 1'b0;
    exp_ev = '{102, 8, 111, 17};
    check("rr event count", n_ev, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < n_ev) check("rr grant order/cycle", ev[i], exp_ev[i]);
      else check("rr missing event", 0, exp_ev[i]);
    end
    @(negedge clk);

    // clr during the 3rd beat of an IF read
    IF_req = 1'b1; IF_addr = 32'h100;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("clr if mem_a beat2", mem_a, 32'h102);
    clr = 1'b1; IF_req = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    check("clr if no done", IF_done, 0);
    lsb_txn("clr then ld", 1'b0, 32'h21, 2'd0, 32'h0, 2, 32'h000000CD);
    check("clr if still no done", IF_done, 0);

    // clr during a 4-byte store: all beats still happen
    wd = 32'h11223344;
    LSB_req = 1'b1; LSB_wr = 1'b1; LSB_addr = 32'h40; LSB_size = 2'd2; LSB_wdata = wd;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      clr = (j == 1);
      check("clr st mem_wr", mem_wr, 1);
      check("clr st mem_a", mem_a, 32'h40 + j);
      check("clr st mem_dout", mem_dout, (wd >> (8 * j)) & 32'hFF);
    end
    @(negedge clk);
    clr = 1'b0;
    check("clr st mem_wr end", mem_wr, 0);
    check("clr st done", LSB_done, 1);
    LSB_req = 1'b0;
    check("clr st ram", {ram[12'h043], ram[12'h042], ram[12'h041], ram[12'h040]}, 32'h11223344);
    @(negedge clk);

    // rdy low for 3 cycles mid-read
    IF_req = 1'b1; IF_addr = 32'h100;
    @(negedge clk);
    @(negedge clk);
    rdy = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check("stall rd mem_a", mem_a, 32'h101);
      check("stall rd mem_wr", mem_wr, 0);
      check("stall rd no done", IF_done, 0);
    end
    rdy = 1'b1;
    wait_done(1'b0, 10, cyc);
    check("stall rd resume latency", cyc, 3);
    check("stall rd data", IF_data, 32'h93000013);
    IF_req = 1'b0;
    @(negedge clk);

    // rdy low during a 2-byte store gates mem_wr
    LSB_req = 1'b1; LSB_wr = 1'b1; LSB_addr = 32'h50; LSB_size = 2'd1; LSB_wdata = 32'h0000BEEF;
    @(negedge clk);
    check("stall st mem_wr", mem_wr, 1);
    rdy = 1'b0;
    #1;
    check("stall st mem_wr gated", mem_wr, 0);
    @(negedge clk);
    check("stall st mem_wr gated 2", mem_wr, 0);
    @(negedge clk);
    rdy = 1'b1;
    #1;
    check("stall st mem_wr back", mem_wr, 1);
    check("stall st mem_a hold", mem_a, 32'h50);
    @(negedge clk);
    check("stall st beat1 mem_a", mem_a, 32'h51);
    check("stall st beat1 dout", mem_dout, 8'hBE);
    @(negedge clk);
    check("stall st done", LSB_done, 1);
    LSB_req = 1'b0;
    check("stall st ram", {ram[12'h051], ram[12'h050]}, 16'hBEEF);
    @(negedge clk);

    // Async reset mid-transaction
    IF_req = 1'b1; IF_addr = 32'h100;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst mem_a", mem_a, 0);
    check("arst IF_data", IF_data, 0);
    IF_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (IF_done) seen = 1'b1;
    end
    check("arst no done", seen, 0);

    // io_buffer_full with an I/O-mapped store (last grant is IF after reset)
    io_buffer_full = 1'b1;
    LSB_req = 1'b1; LSB_wr = 1'b1; LSB_addr = 32'h30000; LSB_size = 2'd0; LSB_wdata = 32'h5A;
    IF_req = 1'b1; IF_addr = 32'h100;
`ifdef MEM_ARBITER_IO_STALL_EN
    seen = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (mem_wr || LSB_done) seen = 1'b1;
    end while (!IF_done && cyc < 10);
    check("io if latency", cyc, 5);
    check("io store held", seen, 0);
    IF_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("io store still held", mem_wr, 0);
    end
    io_buffer_full = 1'b0;
    wait_done(1'b1, 10, cyc);
    check("io store latency", cyc, 2);
    check("io store ram", ram[12'h000], 8'h5A);
    LSB_req = 1'b0;
    @(negedge clk);
`else
    @(negedge clk);
    check("io ignored mem_wr", mem_wr, 1);
    check("io ignored mem_a", mem_a, 32'h30000);
    @(negedge clk);
    check("io ignored done", LSB_done, 1);
    LSB_req = 1'b0;
    wait_done(1'b0, 10, cyc);
    check("io ignored if latency", cyc, 6);
    check("io ignored ram", ram[12'h000], 8'h5A);
    IF_req = 1'b0;
    io_buffer_full = 1'b0;
    @(negedge clk);
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
